// File: rtl/seq_detect_gen.sv
// Serial pattern detector with PAT_W-bit window and fill count; optional saturating match counter (SEQ_DETECT_GEN_CNT_EN).
// Latency: Out1 pulses one cycle after the sample that completes the pattern.
// Backpressure: none; En gates sampling and Clr synchronously clears state.
module seq_detect_gen #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             En,
    input  logic             Clr,
    input  logic             In1,
    output logic             Out1,
    output logic             Busy,
    output logic [CNT_W-1:0] MatchCnt
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  win;
    logic [PAT_W-1:0]  win_d;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_inc;
    logic [FILL_W-1:0] fill_d;
    logic              hit;
    logic              out_q;
    logic              busy_q;

    always_comb begin
        win_d    = win;
        fill_d   = fill;
        fill_inc = (fill == FULL) ? fill : fill + 1'b1;
        hit      = 1'b0;
        if (Clr) begin
            win_d  = '0;
            fill_d = '0;
        end else if (En) begin
            win_d  = {win[PAT_W-2:0], In1};
            hit    = (win_d == PATTERN) && (fill_inc == FULL);
            // Non-overlapping mode restarts the fill so no bit is shared between matches.
            fill_d = (hit && (OVERLAP == 0)) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            win    <= '0;
            fill   <= '0;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            win    <= win_d;
            fill   <= fill_d;
            out_q  <= hit;
            busy_q <= (fill_d != '0);
        end
    end

    assign Out1 = out_q;
    assign Busy = busy_q;

`ifdef SEQ_DETECT_GEN_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (Clr) begin
            cnt <= '0;
        end else if (hit && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign MatchCnt = cnt;
`else
    assign MatchCnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_gen.sv
// Bench for seq_detect_gen: three instances (overlap, non-overlap, 2-bit counter) share one directed stimulus stream.
module tb_seq_detect_gen;

`ifdef SEQ_DETECT_GEN_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    localparam int OVL[3]  = '{1, 0, 1};
    localparam int CMAX[3] = '{255, 255, 3};

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic En  = 1'b0;
    logic Clr = 1'b0;
    logic In1 = 1'b0;

    logic       out_w [3];
    logic       busy_w[3];
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    int         act_cnt[3];

    always #5 CLK = ~CLK;

    seq_detect_gen #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_ov (
        .CLK(CLK), .RST(RST), .En(En), .Clr(Clr), .In1(In1),
        .Out1(out_w[0]), .Busy(busy_w[0]), .MatchCnt(cnt0));

    seq_detect_gen #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_no (
        .CLK(CLK), .RST(RST), .En(En), .Clr(Clr), .In1(In1),
        .Out1(out_w[1]), .Busy(busy_w[1]), .MatchCnt(cnt1));

    seq_detect_gen #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(RST), .En(En), .Clr(Clr), .In1(In1),
        .Out1(out_w[2]), .Busy(busy_w[2]), .MatchCnt(cnt2));

    always_comb begin
        act_cnt[0] = int'(cnt0);
        act_cnt[1] = int'(cnt1);
        act_cnt[2] = int'(cnt2);
    end

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model: bits seen since the last restart, and the value of the last four of them.
    int blen[3] = '{0, 0, 0};
    int bval[3] = '{0, 0, 0};
    int mcnt[3] = '{0, 0, 0};
    bit mout[3] = '{0, 0, 0};

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 3; i++) begin
                blen[i] <= 0; bval[i] <= 0; mcnt[i] <= 0; mout[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int l, v, c;
                bit m;
                l = blen[i]; v = bval[i]; c = mcnt[i]; m = 0;
                if (Clr) begin
                    l = 0; v = 0; c = 0;
                end else if (En) begin
                    v = (v * 2 + int'(In1)) % 16;
                    l = l + 1;
                    if (l >= 4 && v == 11) begin
                        m = 1;
                        if (c < CMAX[i]) c = c + 1;
                        if (OVL[i] == 0) l = 0;
                    end
                end
                blen[i] <= l; bval[i] <= v; mcnt[i] <= c; mout[i] <= m;
            end
        end
    end

    bit chk_en = 0;
    int pulses[3] = '{0, 0, 0};

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("out[%0d]", i), int'(out_w[i]), int'(mout[i]));
                chk($sformatf("busy[%0d]", i), int'(busy_w[i]), (blen[i] != 0) ? 1 : 0);
                chk($sformatf("cnt[%0d]", i), act_cnt[i], CNT_ON ? mcnt[i] : 0);
                if (out_w[i]) pulses[i] = pulses[i] + 1;
            end
        end
    end

    task automatic step(input bit e, input bit c, input bit d);
        En = e; Clr = c; In1 = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_pulses();
        for (int i = 0; i < 3; i++) pulses[i] = 0;
    endtask

    function automatic int ec(input int v);
        return CNT_ON ? v : 0;
    endfunction

    initial begin
        #1 RST = 1'b0;
        @(posedge CLK); #1;
        chk("rst_out", int'(out_w[0]), 0);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_cnt", act_cnt[0], 0);
        chk_en = 1;
        @(posedge CLK); #1;
        RST = 1'b1;

        // Overlap versus non-overlap on 1,0,1,1,0,1,1
        step(0, 1, 0);
        clr_pulses();
        step(1, 0, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
        chk("ov_out_s4", int'(out_w[0]), 1);
        chk("no_out_s4", int'(out_w[1]), 1);
        step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
        chk("ov_out_s7", int'(out_w[0]), 1);
        chk("no_out_s7", int'(out_w[1]), 0);
        step(0, 0, 0);
        chk("ov_pulses", pulses[0], 2);
        chk("no_pulses", pulses[1], 1);
        chk("ov_cnt", act_cnt[0], ec(2));
        chk("no_cnt", act_cnt[1], ec(1));
        chk("no_fill", int'(dut_no.fill), 3);
        chk("no_busy", int'(busy_w[1]), 1);

        // En gating: 1,0,[gap x3],1,1
        step(0, 1, 0);
        clr_pulses();
        step(1, 0, 1); step(1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0);
            chk("gap_out", int'(out_w[0]), 0);
        end
        step(1, 0, 1); step(1, 0, 1);
        chk("gate_out", int'(out_w[0]), 1);
        step(0, 0, 0);
        chk("gate_pulses", pulses[0], 1);

        // Counter saturation with CNT_W=2
        step(0, 1, 0);
        clr_pulses();
        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
            chk("sat_out", int'(out_w[2]), 1);
            if (k == 3 || k == 5) chk("sat_cnt", act_cnt[2], ec(3));
        end
        step(0, 0, 0);
        chk("sat_pulses", pulses[2], 5);
        chk("sat_ov_cnt", act_cnt[0], ec(5));

        // Asynchronous reset mid-pattern
        step(0, 1, 0);
        step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
        chk("pre_rst_busy", int'(busy_w[0]), 1);
        #2 RST = 1'b0;
        #1;
        chk("async_busy", int'(busy_w[0]), 0);
        chk("async_busy_no", int'(busy_w[1]), 0);
        chk("async_cnt", act_cnt[0], 0);
        RST = 1'b1;
        clr_pulses();
        step(1, 0, 1);
        chk("post_rst_out", int'(out_w[0]), 0);
        step(0, 0, 0);
        chk("post_rst_pulses", pulses[0], 0);

        // Clr colliding with the completing sample
        step(1, 0, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
        chk("pre_clr_cnt", act_cnt[0], ec(1));
        step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
        step(1, 1, 1);
        chk("clr_out", int'(out_w[0]), 0);
        chk("clr_busy", int'(busy_w[0]), 0);
        chk("clr_cnt", act_cnt[0], 0);
        step(0, 0, 0);
        step(0, 0, 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
